// File: rtl/decrypt_round_engine.sv
// decrypt_round_engine: iterative AES inverse cipher, one round per clock, external round-key store.
//   clk       rising-edge system clock
//   rst_n     asynchronous active-low reset
//   flush     synchronous abort back to IDLE
//   in_valid  / in_ready / in_data   ciphertext handshake (byte 0 in [127:120])
//   key_idx   index of the round key needed this cycle
//   round_key round key for key_idx, supplied combinationally
//   out_valid / out_ready / out_data plaintext handshake
module decrypt_round_engine #(
    parameter int NR  = 10,
    parameter int KIW = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_data,
    output logic [KIW-1:0]   key_idx,
    input  logic [127:0]     round_key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data
);
    if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
        $error("decrypt_round_engine: NR must be 10, 12 or 14");
    end
    if (KIW < 4) begin : g_bad_kiw
        $error("decrypt_round_engine: KIW must be at least 4");
    end

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

    fsm_t           fsm, fsm_nxt;
    logic [KIW-1:0] rnd;
    logic [127:0]   state;
    logic [127:0]   ark;
    logic [127:0]   first_st;
    logic [127:0]   mid_st;

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = INV_SBOX[s[8*i +: 8]];
        return o;
    endfunction

    // Row r of the column-major state rotates right by r positions.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiples 9/11/13/14 are built from the xtime chain x2, x4, x8.
    function automatic logic [31:0] imc_col(input logic [31:0] col);
        logic [7:0]  a, x2, x4, x8;
        logic [7:0]  m9 [4];
        logic [7:0]  m11[4];
        logic [7:0]  m13[4];
        logic [7:0]  m14[4];
        logic [31:0] o;
        for (int r = 0; r < 4; r++) begin
            a      = col[31-8*r -: 8];
            x2     = xt(a);
            x4     = xt(x2);
            x8     = xt(x4);
            m9[r]  = x8 ^ a;
            m11[r] = x8 ^ x2 ^ a;
            m13[r] = x8 ^ x4 ^ a;
            m14[r] = x8 ^ x4 ^ x2;
        end
        for (int r = 0; r < 4; r++)
            o[31-8*r -: 8] = m14[r] ^ m11[(r+1)%4] ^ m13[(r+2)%4] ^ m9[(r+3)%4];
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) o[127-32*c -: 32] = imc_col(s[127-32*c -: 32]);
        return o;
    endfunction

    // The same AddRoundKey feeds both the initial round (from in_data) and the middle rounds.
    always_comb begin
        ark      = ((fsm == IDLE) ? in_data : state) ^ round_key;
        first_st = inv_sub_bytes(inv_shift_rows(ark));
        mid_st   = inv_sub_bytes(inv_shift_rows(inv_mix_columns(ark)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fsm <= IDLE;
        else        fsm <= fsm_nxt;
    end

    always_comb begin
        fsm_nxt = fsm;
        if (flush)                                 fsm_nxt = IDLE;
        else if (fsm == IDLE && in_valid)          fsm_nxt = ROUND;
        else if (fsm == ROUND && rnd == '0)        fsm_nxt = DONE;
        else if (fsm == DONE && out_ready)         fsm_nxt = IDLE;
    end

    always_comb begin
        in_ready  = (fsm == IDLE);
        out_valid = (fsm == DONE);
        key_idx   = (fsm == ROUND) ? rnd : KIW'(NR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rnd      <= '0;
            state    <= '0;
            out_data <= '0;
        end else if (flush) begin
            rnd   <= '0;
            state <= '0;
        end else if (fsm == IDLE && in_valid) begin
            state <= first_st;
            rnd   <= KIW'(NR - 1);
        end else if (fsm == ROUND) begin
            if (rnd != '0) begin
                state <= mid_st;
                rnd   <= rnd - KIW'(1);
            end else begin
                out_data <= ark;
            end
        end
    end
endmodule

// File: tb/tb_decrypt_round_engine.sv
// tb_decrypt_round_engine: randomized self-checking bench against a FIPS-197 inverse-cipher model.
module tb_decrypt_round_engine;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         fl[2];
    logic         iv[2];
    logic         ir[2];
    logic         ov[2];
    logic         ordy[2];
    logic [127:0] id[2];
    logic [127:0] od[2];
    logic [127:0] rkey[2];
    logic [3:0]   ki[2];
    logic [127:0] rk[2][16];
    logic [7:0]   sb[256];
    logic [7:0]   isb[256];
    int           n_tests = 0;
    int           n_fail = 0;

    localparam logic [255:0] KEY10 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY14 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT10  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT14  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;

    always #5 clk = ~clk;

    decrypt_round_engine #(.NR(10), .KIW(4)) dut10 (
        .clk(clk), .rst_n(rst_n), .flush(fl[0]), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_data(id[0]), .key_idx(ki[0]), .round_key(rkey[0]), .out_valid(ov[0]),
        .out_ready(ordy[0]), .out_data(od[0]));

    decrypt_round_engine #(.NR(14), .KIW(4)) dut14 (
        .clk(clk), .rst_n(rst_n), .flush(fl[1]), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_data(id[1]), .key_idx(ki[1]), .round_key(rkey[1]), .out_valid(ov[1]),
        .out_ready(ordy[1]), .out_data(od[1]));

    always_comb begin
        rkey[0] = rk[0][ki[0]];
        rkey[1] = rk[1][ki[1]];
    end

    function automatic int nr_of(int s);
        return (s != 0) ? 14 : 10;
    endfunction

    task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(logic [7:0] v, int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // S-box from its definition: multiplicative inverse then affine map.
    task automatic init_tables();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sb[x]  = s;
            isb[s] = 8'(x);
        end
    endtask

    function automatic logic [31:0] subw(logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    task automatic expand_key(int s, logic [255:0] key);
        logic [31:0] w[64];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        int nr = nr_of(s);
        int nk = nr - 6;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) rk[s][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] m_isb(logic [127:0] v);
        logic [127:0] o;
        for (int j = 0; j < 16; j++) o[127-8*j -: 8] = isb[v[127-8*j -: 8]];
        return o;
    endfunction

    function automatic logic [127:0] m_isr(logic [127:0] v);
        logic [7:0]   m[4][4];
        logic [127:0] o;
        for (int c = 0; c < 4; c++) for (int r = 0; r < 4; r++) m[r][c] = v[127-8*(4*c+r) -: 8];
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) o[127-8*(4*((c+r)%4)+r) -: 8] = m[r][c];
        return o;
    endfunction

    function automatic logic [127:0] m_imc(logic [127:0] v);
        logic [7:0]   coef[4] = '{8'd14, 8'd11, 8'd13, 8'd9};
        logic [7:0]   b;
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                b = 8'h00;
                for (int k = 0; k < 4; k++) b ^= gmul(coef[(k-r+4)%4], v[127-8*(4*c+k) -: 8]);
                o[127-8*(4*c+r) -: 8] = b;
            end
        return o;
    endfunction

    // Textbook InvCipher ordering: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns.
    function automatic logic [127:0] model_dec(int s, logic [127:0] ct);
        int nr = nr_of(s);
        logic [127:0] v = ct ^ rk[s][nr];
        for (int r = nr - 1; r >= 1; r--) v = m_imc(m_isb(m_isr(v)) ^ rk[s][r]);
        return m_isb(m_isr(v)) ^ rk[s][0];
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(int s, logic [127:0] ct, logic [127:0] exp, int hold);
        int n = 0;
        int nr = nr_of(s);
        while (!ir[s] && n < 50) begin step(); n++; end
        chk("ready", ir[s], 1);
        chk("kidx_idle", ki[s], nr);
        iv[s] = 1'b1;
        id[s] = ct;
        step();
        iv[s] = 1'b0;
        id[s] = rand128();
        n = 1;
        while (!ov[s] && n < 40) begin
            chk("kidx_round", ki[s], nr - n);
            chk("busy_ready", ir[s], 0);
            ordy[s] = 1'($urandom % 2);
            step();
            n++;
        end
        ordy[s] = 1'b0;
        chk("latency", n, nr + 1);
        chk("plaintext", od[s], exp);
        for (int i = 0; i < hold; i++) begin
            step();
            chk("hold_data", od[s], exp);
            chk("hold_valid", ov[s], 1);
            chk("hold_ready", ir[s], 0);
        end
        ordy[s] = 1'b1;
        step();
        ordy[s] = 1'b0;
        chk("ret_ready", ir[s], 1);
        chk("ret_valid", ov[s], 0);
    endtask

    task automatic no_output(string tag, int cycles);
        logic seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin step(); seen |= ov[0]; end
        chk(tag, seen, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] cts[3];
        logic [127:0] exps[3];
        logic [127:0] got[$];
        int           acc[$];
        logic [127:0] ct;
        int           n, idx, cyc, s;
        logic         accepted, fire;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            fl[i] = 1'b0; iv[i] = 1'b0; ordy[i] = 1'b0; id[i] = '0;
            for (int r = 0; r < 16; r++) rk[i][r] = '0;
        end
        init_tables();
        expand_key(0, KEY10);
        expand_key(1, KEY14);
        #23;
        for (int i = 0; i < 2; i++) begin
            chk("rst_ready", ir[i], 1);
            chk("rst_valid", ov[i], 0);
            chk("rst_kidx", ki[i], nr_of(i));
            chk("rst_data", od[i], 0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        run_vec(0, CT10, PT, 0);
        run_vec(1, CT14, PT, 2);
        run_vec(0, CT10, PT, 5);

        for (int t = 0; t < 6; t++) begin
            s = t % 2;
            expand_key(s, rand128() == 0 ? KEY14 : {rand128(), rand128()});
            ct = rand128();
            run_vec(s, ct, model_dec(s, ct), int'($urandom_range(0, 3)));
        end
        expand_key(0, KEY10);
        expand_key(1, KEY14);

        iv[0] = 1'b1;
        id[0] = CT10;
        step();
        iv[0] = 1'b0;
        n = 0;
        while (ki[0] != 4'd4 && n < 20) begin step(); n++; end
        chk("flush_at_rnd4", ki[0], 4);
        fl[0] = 1'b1;
        step();
        fl[0] = 1'b0;
        chk("flush_ready", ir[0], 1);
        chk("flush_valid", ov[0], 0);
        chk("flush_kidx", ki[0], 10);
        no_output("flush_no_out", 15);
        run_vec(0, CT10, PT, 1);

        fl[0] = 1'b1;
        iv[0] = 1'b1;
        id[0] = CT10;
        step();
        fl[0] = 1'b0;
        iv[0] = 1'b0;
        chk("flush_over_accept", ir[0], 1);
        no_output("flush_accept_no_out", 14);

        iv[0] = 1'b1;
        id[0] = CT10;
        step();
        iv[0] = 1'b0;
        n = 0;
        while (!ov[0] && n < 20) begin step(); n++; end
        chk("pre_flush_done", ov[0], 1);
        ordy[0] = 1'b1;
        fl[0] = 1'b1;
        step();
        fl[0] = 1'b0;
        ordy[0] = 1'b0;
        chk("flush_done_valid", ov[0], 0);
        chk("flush_done_ready", ir[0], 1);
        no_output("flush_done_no_out", 3);

        iv[0] = 1'b1;
        id[0] = CT10;
        step();
        iv[0] = 1'b0;
        n = 0;
        while (!ov[0] && n < 20) begin step(); n++; end
        chk("pre_reset_done", ov[0], 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", ov[0], 0);
        chk("arst_ready", ir[0], 1);
        chk("arst_kidx", ki[0], 10);
        chk("arst_data", od[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        no_output("arst_no_out", 15);
        run_vec(0, CT10, PT, 0);

        for (int i = 0; i < 3; i++) begin
            cts[i]  = rand128();
            exps[i] = model_dec(0, cts[i]);
        end
        idx = 0;
        cyc = 0;
        iv[0] = 1'b1;
        id[0] = cts[0];
        ordy[0] = 1'b1;
        while (got.size() < 3 && cyc < 200) begin
            accepted = ir[0] && iv[0];
            fire = ov[0] && ordy[0];
            if (fire) got.push_back(od[0]);
            step();
            cyc++;
            if (accepted) begin
                acc.push_back(cyc);
                idx++;
                if (idx < 3) id[0] = cts[idx];
                else iv[0] = 1'b0;
            end
        end
        iv[0] = 1'b0;
        ordy[0] = 1'b0;
        chk("b2b_outputs", got.size(), 3);
        chk("b2b_accepts", acc.size(), 3);
        for (int i = 0; i < got.size() && i < 3; i++) chk("b2b_data", got[i], exps[i]);
        for (int i = 1; i < acc.size(); i++) chk("b2b_gap", acc[i] - acc[i-1], 12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/decrypt_round_engine.md
DECRYPT_ROUND_ENGINE -- requirements
Module: decrypt_round_engine

Interface
REQ-001 The block SHALL have parameter NR, default 10, meaning the number of AES rounds; legal values are 10, 12 and 14, and any other value SHALL cause an elaboration error.
REQ-002 The block SHALL have parameter KIW, default 4, meaning the key_idx width; it SHALL be at least 4.
REQ-003 clk  input  1  single system clock; all state SHALL change on its rising edge only.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 flush  input  1  synchronous abort of any operation in progress.
REQ-006 in_valid  input  1  ciphertext offered.
REQ-007 in_ready  output  1  engine can accept a ciphertext.
REQ-008 in_data  input  128  ciphertext, byte 0 in bits [127:120].
REQ-009 key_idx  output  KIW  index of the round key required in the current cycle.
REQ-010 round_key  input  128  round key for key_idx, supplied combinationally in the same cycle by an external key store.
REQ-011 out_valid  output  1  plaintext available.
REQ-012 out_ready  input  1  consumer accepts the plaintext.
REQ-013 out_data  output  128  plaintext, same byte order as in_data.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, ROUND and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-016 In IDLE, key_idx SHALL equal NR.
REQ-017 When in_valid=1 in IDLE, the engine SHALL, on that edge:
- register state = InvSubBytes(InvShiftRows(in_data XOR round_key));
- load the round counter rnd with NR-1;
- move to ROUND.
REQ-018 In ROUND, key_idx SHALL equal rnd.
REQ-019 In ROUND with rnd!=0, the engine SHALL, on each edge:
- register state = InvSubBytes(InvShiftRows(InvMixColumns(state XOR round_key)));
- decrement rnd.
REQ-020 In ROUND with rnd=0, the engine SHALL, on that edge:
- register out_data = state XOR round_key;
- move to DONE.
REQ-021 Latency: out_valid SHALL rise exactly NR+1 rising edges after the accepting edge, counting the accepting edge itself as edge 1 (11 edges for NR=10).
REQ-022 In DONE, out_data SHALL hold stable until out_valid=1 and out_ready=1; on that edge the FSM SHALL return to IDLE.
REQ-023 No new ciphertext SHALL be accepted in the DONE-to-IDLE cycle; minimum issue interval is NR+2 cycles.
REQ-024 When in_valid=0 in IDLE, the FSM, state, rnd and out_data SHALL hold.
REQ-025 flush=1 in any state SHALL, on that edge:
- force IDLE;
- drop out_valid;
- set rnd to 0;
- discard the partial state.
flush SHALL take priority over acceptance and over the DONE handshake.
REQ-026 out_ready SHALL be ignored outside DONE.
REQ-027 Each of the three transforms SHALL be a pure combinational function of its 128-bit input (FIPS-197 inverse S-box, inverse shift, GF(2^8) InvMixColumns with modulus 0x11B); no transform SHALL register internally.
REQ-028 round_key SHALL be sampled only in the cycle key_idx presents its index; key_idx SHALL never exceed NR.

Reset
REQ-029 While rst_n=0:
- FSM=IDLE; rnd=0; key_idx=NR;
- state=0; out_data=0;
- in_ready=1; out_valid=0.
REQ-030 Reset asserted mid-operation SHALL abandon the block immediately; no out_valid pulse SHALL follow deassertion.
REQ-031 The first acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-032 NR=10, key store expanded from key 000102030405060708090a0b0c0d0e0f, in_data=69c4e0d86a7b0430d8cdb78070b4c55a -> out_data=00112233445566778899aabbccddeeff, with out_valid on the 11th edge.
REQ-033 NR=14, key 000102...1e1f, in_data=8ea2b7ca516745bfeafc49904b496089 -> out_data=00112233445566778899aabbccddeeff after 15 edges; key_idx sequence 14,13,...,0 observed.
REQ-034 out_ready held 0 for 5 cycles in DONE -> out_data and out_valid stable throughout; in_ready=0 throughout; IDLE is entered on the edge after out_ready rises.
REQ-035 flush pulsed in ROUND at rnd=4 -> IDLE next cycle with no out_valid; a following REQ-032 vector decrypts correctly.
REQ-036 rst_n pulsed low in DONE while out_ready=0 -> out_valid=0 and in_ready=1 immediately; no stale output after release.
REQ-037 Back-to-back stream of 3 vectors with in_valid and out_ready held 1 -> acceptances exactly NR+2 cycles apart, and results emerge in order.
